// File: rtl/fft_frame_loader.sv
// fft_frame_loader: upstream stage of the parallel FFT.
//
// Collects a valid/ready stream of real samples into frames of SIZE words.
// A fill buffer gathers the next frame while an output register holds the
// current one, so the stream keeps full rate whenever the consumer is ready.
//
// Optional build macro:
//   FFT_FRAME_LOADER_OVERLAP_EN - 50% overlapping frames. Each unpadded frame
//   carries its upper half into the lower half of the next fill.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_data      input sample
//   in_valid     in_data is valid
//   in_ready     loader accepts a sample this cycle
//   flush        zero-pad and close the partial frame
//   frame_out    held frame, index 0 is the oldest sample
//   frame_valid  frame_out holds an untaken frame
//   frame_ready  consumer takes the frame this cycle
//   frame_seq    sequence number of the frame on frame_out
//   frame_padded frame on frame_out was closed by flush
module fft_frame_loader #(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned IN_BITS  = 32,
    parameter int unsigned SEQ_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [IN_BITS-1:0]  frame_out [SIZE],
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [SEQ_BITS-1:0] frame_seq,
    output logic                frame_padded
);

    localparam int unsigned CW = $clog2(SIZE);
`ifdef FFT_FRAME_LOADER_OVERLAP_EN
    localparam int unsigned HALF = SIZE / 2;
`endif

    logic [IN_BITS-1:0]  fill_q [SIZE];
    logic [IN_BITS-1:0]  fill_d [SIZE];
    logic [CW-1:0]       count_q, count_d;
    logic                fill_full_q, fill_full_d;
    logic                pad_q, pad_d;
    logic [SEQ_BITS-1:0] seq_q;

    logic                out_free;
    logic                transfer;
    logic                accept;
    logic [CW-1:0]       base;      // fill index written by a sample this cycle
    logic [CW:0]         next_cnt;  // fill level after this cycle's sample

    assign out_free = !frame_valid || frame_ready;
    assign transfer = fill_full_q && out_free;
    assign in_ready = !fill_full_q || out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fill_d      = fill_q;
        count_d     = count_q;
        fill_full_d = fill_full_q;
        pad_d       = pad_q;
        base        = count_q;

        if (transfer) begin
            fill_full_d = 1'b0;
            pad_d       = 1'b0;
`ifdef FFT_FRAME_LOADER_OVERLAP_EN
            for (int i = 0; i < HALF; i++) begin
                fill_d[CW'(i)] = fill_q[CW'(i + HALF)];
            end
            // A padded frame ends the stream segment: no carry-over.
            base = pad_q ? '0 : CW'(HALF);
`else
            base = '0;
`endif
            count_d = base;
        end

        next_cnt = {1'b0, base} + (CW+1)'(accept);

        if (accept) begin
            fill_d[base] = in_data;
        end

        if (next_cnt == (CW+1)'(SIZE)) begin
            // Sample completed the frame; a coincident flush has nothing to pad.
            fill_full_d = 1'b1;
            count_d     = '0;
            pad_d       = 1'b0;
        end else begin
            count_d = next_cnt[CW-1:0];
            if (flush && !fill_full_q && (next_cnt != '0)) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (i >= int'(next_cnt)) begin
                        fill_d[CW'(i)] = '0;
                    end
                end
                fill_full_d = 1'b1;
                pad_d       = 1'b1;
                count_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q       <= '{default: '0};
            count_q      <= '0;
            fill_full_q  <= 1'b0;
            pad_q        <= 1'b0;
            seq_q        <= '0;
            frame_out    <= '{default: '0};
            frame_valid  <= 1'b0;
            frame_seq    <= '0;
            frame_padded <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            count_q     <= count_d;
            fill_full_q <= fill_full_d;
            pad_q       <= pad_d;
            if (transfer) begin
                frame_out    <= fill_q;
                frame_valid  <= 1'b1;
                frame_seq    <= seq_q;
                seq_q        <= seq_q + 1'b1;
                frame_padded <= pad_q;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: expected frames come from a
// table; stream, backpressure, flush and reset sequences are hand-written.
module tb_fft_frame_loader;

    localparam int SIZE     = 8;
    localparam int IN_BITS  = 32;
    localparam int SEQ_BITS = 16;

    typedef logic [SIZE-1:0][IN_BITS-1:0] pframe_t;

    typedef struct packed {
        pframe_t             d;
        logic [SEQ_BITS-1:0] seq;
        logic                pad;
    } exp_t;

`ifdef FFT_FRAME_LOADER_OVERLAP_EN
    localparam int NEXP = 5;
`else
    localparam int NEXP = 10;
`endif

    logic                clk;
    logic                rst_n;
    logic [IN_BITS-1:0]  in_data;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [IN_BITS-1:0]  frame_out [SIZE];
    logic                frame_valid;
    logic                frame_ready;
    logic [SEQ_BITS-1:0] frame_seq;
    logic                frame_padded;

    fft_frame_loader #(
        .SIZE     (SIZE),
        .IN_BITS  (IN_BITS),
        .SEQ_BITS (SEQ_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_seq    (frame_seq),
        .frame_padded (frame_padded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t tab [NEXP];
    int   checks = 0;
    int   errors = 0;
    int   eidx = 0;
    int   stall_cycles = 0;

    // First n words count up from start, the rest are zero.
    function automatic pframe_t pfx(input int start, input int n);
        pframe_t r;
        for (int i = 0; i < SIZE; i++) begin
            r[i] = (i < n) ? IN_BITS'(start + i) : '0;
        end
        return r;
    endfunction

    function automatic exp_t mke(input pframe_t d, input int seq, input bit pad);
        exp_t e;
        e.d   = d;
        e.seq = SEQ_BITS'(seq);
        e.pad = pad;
        return e;
    endfunction

    function automatic pframe_t pack_out();
        pframe_t r;
        for (int i = 0; i < SIZE; i++) r[i] = frame_out[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_take();
        if (eidx >= NEXP) begin
            checks++;
            errors++;
            $display("FAIL extra_frame got seq=%0d required no frame", frame_seq);
            return;
        end
        chk($sformatf("frame%0d_data", eidx), pack_out(), tab[eidx].d);
        chk($sformatf("frame%0d_seq", eidx), 256'(frame_seq), 256'(tab[eidx].seq));
        chk($sformatf("frame%0d_pad", eidx), 256'(frame_padded), 256'(tab[eidx].pad));
        eidx++;
    endtask

    // One clock; a frame taken on this edge is compared with the table.
    task automatic tick();
        #1;
        if (frame_valid && frame_ready) check_take();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = IN_BITS'(d);
        #1;
        while (!in_ready && guard < 200) begin
            stall_cycles++;
            guard++;
            tick();
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 for 200 cycles required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_frame_valid"}, 256'(frame_valid), 256'(0));
        chk({tag, "_frame_out"}, pack_out(), 256'(0));
        chk({tag, "_frame_seq"}, 256'(frame_seq), 256'(0));
        chk({tag, "_frame_padded"}, 256'(frame_padded), 256'(0));
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
`ifdef FFT_FRAME_LOADER_OVERLAP_EN
        tab[0] = mke(pfx(1, 8), 0, 1'b0);
        tab[1] = mke(pfx(5, 8), 1, 1'b0);
        tab[2] = mke(pfx(9, 8), 2, 1'b0);
        tab[3] = mke(pfx(13, 4), 3, 1'b1);
        tab[4] = mke(pfx(1, 8), 4, 1'b0);
`else
        tab[0] = mke(pfx(1, 8), 0, 1'b0);
        tab[1] = mke(pfx(9, 8), 1, 1'b0);
        tab[2] = mke(pfx(1, 8), 2, 1'b0);
        tab[3] = mke(pfx(9, 8), 3, 1'b0);
        tab[4] = mke(pfx(17, 8), 4, 1'b0);
        tab[5] = mke(pfx(5, 3), 5, 1'b1);
        tab[6] = mke(pfx(1, 3), 6, 1'b1);
        tab[7] = mke(pfx(1, 8), 7, 1'b0);
        tab[8] = mke(pfx(11, 8), 0, 1'b0);
        tab[9] = mke(pfx(1, 1), 1, 1'b0);
`endif

        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        do_reset();
        check_reset_state("reset");

        // Continuous stream with an always-ready consumer.
        frame_ready  = 1'b1;
        stall_cycles = 0;
        for (int i = 1; i <= 16; i++) begin
            send(i);
`ifndef FFT_FRAME_LOADER_OVERLAP_EN
            if (i == 8) chk("latency_before", 256'(frame_valid), 256'(0));
            if (i == 9) chk("latency_after", 256'(frame_valid), 256'(1));
`endif
        end
        chk("stream_no_stall", 256'(stall_cycles), 256'(0));
        drain(3);

`ifdef FFT_FRAME_LOADER_OVERLAP_EN
        // Fill holds 13..16 carried over; flush pads it, then count restarts at 0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(3);
        for (int i = 1; i <= 8; i++) send(i);
        drain(3);
`else
        // Backpressure: frame 1..8 held, fill 9..16 blocks the next sample.
        frame_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(i);
        in_valid = 1'b1;
        in_data  = IN_BITS'(17);
        #1;
        chk("bp_in_ready_low", 256'(in_ready), 256'(0));
        tick();
        tick();
        chk("bp_held_valid", 256'(frame_valid), 256'(1));
        chk("bp_held_word0", 256'(frame_out[0]), 256'(1));
        chk("bp_held_seq", 256'(frame_seq), 256'(2));
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        for (int i = 17; i <= 24; i++) send(i);
        drain(4);

        // Flush of a partial frame.
        send(5);
        send(6);
        send(7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(3);

        // Flush together with a sample: sample lands first, padding after it.
        send(1);
        send(2);
        flush = 1'b1;
        send(3);
        flush = 1'b0;
        drain(3);

        // Flush together with the completing sample: not padded.
        for (int i = 1; i <= 7; i++) send(i);
        flush = 1'b1;
        send(8);
        flush = 1'b0;
        drain(3);

        // Flush with an empty fill produces nothing.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(4);
        chk("empty_flush_valid", 256'(frame_valid), 256'(0));
        chk("empty_flush_count", 256'(eidx), 256'(8));

        // Reset mid-frame discards the partial fill.
        for (int i = 21; i <= 24; i++) send(i);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("midreset");
        for (int i = 11; i <= 18; i++) send(i);
        drain(3);

        // Impulse frame: every DFT bin must be 1 + 0j.
        send(1);
        for (int i = 0; i < 7; i++) send(0);
        tick();
        chk("impulse_valid", 256'(frame_valid), 256'(1));
        for (int k = 0; k < SIZE; k++) begin
            real re, im, ang, x;
            re = 0.0;
            im = 0.0;
            for (int n = 0; n < SIZE; n++) begin
                x   = $itor($signed(frame_out[n]));
                ang = 2.0 * 3.14159265358979 * real'(k * n) / real'(SIZE);
                re  = re + x * $cos(ang);
                im  = im - x * $sin(ang);
            end
            checks++;
            if (!(re > 0.999 && re < 1.001 && im > -0.001 && im < 0.001)) begin
                errors++;
                $display("FAIL dft_bin%0d got re=%f im=%f required re=1 im=0", k, re, im);
            end
        end
        drain(3);
`endif

        chk("frames_seen", 256'(eidx), 256'(NEXP));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
